// File: rtl/edge_det_pkg.sv
// Shared mode encoding for the multi-channel edge detector.
// Each mode bit enables one edge direction.
package edge_det_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
  localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;
endpackage

// File: rtl/edge_det_ch.sv
// One edge-detector channel: synchroniser, debounce filter, mode-gated edge
// detection, sticky pending flag and saturating event counter.
module edge_det_ch
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_sig,
  input  logic [MODE_W-1:0] mode,
  input  logic              clr,
  output logic              out_sig,
  output logic              pend,
  output logic [CNT_W-1:0]  cnt,
  output logic              lvl
);
  localparam int DC_W = $clog2(DEB_CYC) + 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_s;
  logic              r_flt;
  logic              r_flt_d;
  logic [DC_W-1:0]   r_dc;
  logic              r_out;
  logic              r_pend;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_rise;
  logic              w_fall;
  logic              w_ev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = in_sig;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= in_sig;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // A new level is accepted only after DEB_CYC consecutive matching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flt <= 1'b0;
      r_dc  <= '0;
    end else if (w_s == r_flt) begin
      r_dc <= '0;
    end else if (r_dc == DC_LAST) begin
      r_flt <= w_s;
      r_dc  <= '0;
    end else begin
      r_dc <= r_dc + DC_W'(1);
    end
  end

  assign w_rise = r_flt & ~r_flt_d;
  assign w_fall = ~r_flt & r_flt_d;
  assign w_ev   = (w_rise & |(mode & MODE_RISE)) | (w_fall & |(mode & MODE_FALL));

  // Set beats clear; clear coinciding with an event restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flt_d <= 1'b0;
      r_out   <= 1'b0;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_flt_d <= r_flt;
      r_out   <= w_ev;
      if (w_ev)     r_pend <= 1'b1;
      else if (clr) r_pend <= 1'b0;
      if (w_ev) begin
        if (clr)                   r_cnt <= CNT_W'(1);
        else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end else if (clr) begin
        r_cnt <= '0;
      end
    end
  end

  assign out_sig = r_out;
  assign pend    = r_pend;
  assign cnt     = r_cnt;
  assign lvl     = r_flt;
endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent edge-detector channels with a shared interrupt that is
// the OR of all pending flags.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 3,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_sig,
  input  logic [MODE_W*N_CH-1:0]  mode,
  input  logic [N_CH-1:0]         clr,
  output logic [N_CH-1:0]         out_sig,
  output logic [N_CH-1:0]         pend,
  output logic [N_CH*CNT_W-1:0]   cnt,
  output logic [N_CH-1:0]         lvl,
  output logic                    irq
);
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_det_ch #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYC    (DEB_CYC),
        .CNT_W      (CNT_W)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .in_sig (in_sig[i]),
        .mode   (mode[i*MODE_W +: MODE_W]),
        .clr    (clr[i]),
        .out_sig(out_sig[i]),
        .pend   (pend[i]),
        .cnt    (cnt[i*CNT_W +: CNT_W]),
        .lvl    (lvl[i])
      );
    end
  endgenerate

  assign irq = |pend;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with hand-computed expectations;
// inputs change and outputs are sampled on the falling clock edge.
module tb_multi_edge_detector;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_sig;
  logic [7:0]  mode;
  logic [3:0]  clr;
  logic [3:0]  out_sig;
  logic [3:0]  pend;
  logic [31:0] cnt;
  logic [3:0]  lvl;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses[4];
  logic [3:0] lvl_seen;

  multi_edge_detector #(
    .N_CH(4), .SYNC_STAGES(2), .DEB_CYC(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_sig(in_sig), .mode(mode), .clr(clr),
    .out_sig(out_sig), .pend(pend), .cnt(cnt), .lvl(lvl), .irq(irq)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    lvl_seen = 4'h0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (out_sig[i] === 1'b1) pulses[i]++;
      lvl_seen = lvl_seen | lvl;
    end
  endtask

  initial begin
    clear_mon();
    // 1: reset with inputs high, then release
    rst = 1'b1; in_sig = 4'hF; mode = 8'h55; clr = 4'h0;
    tick(4);
    check("rst_out",  {28'h0, out_sig}, 32'h0);
    check("rst_pend", {28'h0, pend}, 32'h0);
    check("rst_cnt",  cnt, 32'h0);
    check("rst_lvl",  {28'h0, lvl}, 32'h0);
    check("rst_irq",  {31'h0, irq}, 32'h0);
    rst = 1'b0;
    tick(5);
    check("t1_out_early", {28'h0, out_sig}, 32'h0);
    check("t1_lvl",       {28'h0, lvl}, 32'hF);
    tick(1);
    check("t1_out",  {28'h0, out_sig}, 32'hF);
    check("t1_pend", {28'h0, pend}, 32'hF);
    check("t1_cnt",  cnt, 32'h01010101);
    check("t1_irq",  {31'h0, irq}, 32'h1);
    tick(1);
    check("t1_out_one", {28'h0, out_sig}, 32'h0);

    in_sig = 4'h0; mode = 8'h00;
    tick(8);
    clr = 4'hF;
    tick(1);
    clr = 4'h0;
    check("clr_pend", {28'h0, pend}, 32'h0);
    check("clr_cnt",  cnt, 32'h0);
    check("clr_irq",  {31'h0, irq}, 32'h0);
    check("clr_lvl",  {28'h0, lvl}, 32'h0);

    // 2: channel 0 rise only
    mode = 8'h01; clear_mon();
    in_sig = 4'h1;
    tick(5);
    check("t2_out_early", {31'h0, out_sig[0]}, 32'h0);
    check("t2_lvl",       {31'h0, lvl[0]}, 32'h1);
    tick(1);
    check("t2_out",  {31'h0, out_sig[0]}, 32'h1);
    check("t2_cnt0", {24'h0, cnt[7:0]}, 32'h1);
    tick(4);
    in_sig = 4'h0;
    tick(10);
    check("t2_lvl_low", {31'h0, lvl[0]}, 32'h0);
    check("t2_pulses",  pulses[0], 32'd1);
    check("t2_cnt0_after", {24'h0, cnt[7:0]}, 32'h1);

    // 3: channel 1 debounce, both edges
    mode = 8'h0D; clear_mon();
    in_sig = 4'h2;
    tick(2);
    in_sig = 4'h0;
    tick(8);
    check("t3_glitch_pulses", pulses[1], 32'd0);
    check("t3_glitch_lvl",    {31'h0, lvl_seen[1]}, 32'h0);
    in_sig = 4'h2;
    tick(3);
    in_sig = 4'h0;
    tick(10);
    check("t3_pulses",    pulses[1], 32'd2);
    check("t3_cnt1",      {24'h0, cnt[15:8]}, 32'h2);
    check("t3_lvl_end",   {31'h0, lvl[1]}, 32'h0);
    check("t3_ch0_quiet", pulses[0], 32'd0);

    // 4: channel 2 saturation
    mode = 8'h3D;
    for (int i = 0; i < 300; i++) begin
      in_sig[2] = ~in_sig[2];
      tick(6);
      if (i == 99) check("t4_cnt2_100", {24'h0, cnt[23:16]}, 32'd100);
    end
    check("t4_cnt2_sat", {24'h0, cnt[23:16]}, 32'd255);
    check("t4_pend2",    {31'h0, pend[2]}, 32'h1);

    // 5: channel 3 clear behaviour
    mode = 8'h7D;
    in_sig[3] = 1'b1;
    tick(8);
    check("t5_cnt3_first", {24'h0, cnt[31:24]}, 32'h1);
    in_sig[3] = 1'b0;
    tick(8);
    in_sig[3] = 1'b1;
    tick(5);
    clr = 4'h8;
    tick(1);
    clr = 4'h0;
    check("t5_out3_clr_ev",  {31'h0, out_sig[3]}, 32'h1);
    check("t5_pend3_clr_ev", {31'h0, pend[3]}, 32'h1);
    check("t5_cnt3_clr_ev",  {24'h0, cnt[31:24]}, 32'h1);
    tick(3);
    clr = 4'h8;
    tick(1);
    clr = 4'h0;
    check("t5_pend3_clr", {31'h0, pend[3]}, 32'h0);
    check("t5_cnt3_clr",  {24'h0, cnt[31:24]}, 32'h0);
    check("t5_irq_others", {31'h0, irq}, 32'h1);
    clr = 4'hF;
    tick(1);
    clr = 4'h0;
    check("t5_pend_all", {28'h0, pend}, 32'h0);
    check("t5_irq_off",  {31'h0, irq}, 32'h0);

    // 6: channel 0 mode off, then enable while high
    mode = 8'h7C; clear_mon();
    in_sig[0] = 1'b1;
    tick(8);
    check("t6_lvl_hi1", {31'h0, lvl[0]}, 32'h1);
    in_sig[0] = 1'b0;
    tick(8);
    check("t6_lvl_lo", {31'h0, lvl[0]}, 32'h0);
    in_sig[0] = 1'b1;
    tick(8);
    check("t6_lvl_hi2",  {31'h0, lvl[0]}, 32'h1);
    check("t6_off_puls", pulses[0], 32'd0);
    check("t6_off_pend", {31'h0, pend[0]}, 32'h0);
    check("t6_off_cnt",  {24'h0, cnt[7:0]}, 32'h0);
    mode = 8'h7D;
    tick(8);
    check("t6_enable_quiet", pulses[0], 32'd0);
    in_sig[0] = 1'b0;
    tick(8);
    in_sig[0] = 1'b1;
    tick(5);
    check("t6_out_early", {31'h0, out_sig[0]}, 32'h0);
    tick(1);
    check("t6_out",  {31'h0, out_sig[0]}, 32'h1);
    check("t6_cnt0", {24'h0, cnt[7:0]}, 32'h1);

    // mid-operation reset discards state
    rst = 1'b1;
    tick(2);
    check("mr_cnt",  cnt, 32'h0);
    check("mr_pend", {28'h0, pend}, 32'h0);
    check("mr_lvl",  {28'h0, lvl}, 32'h0);
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
